// File: rtl/dds_wave_gen_ctrl.sv
// DDS waveform generator: phase accumulator, push-button control of wave/amp/phase/freq,
// and a three-stage sample pipeline around an external 1-cycle-latency sine ROM.
module dds_wave_gen_ctrl #(
  parameter int               ACC_W       = 32,
  parameter int               ROM_AW      = 9,
  parameter int               DATA_W      = 8,
  parameter int               AMP_W       = 4,
  parameter int               AMP_MAX     = 15,
  parameter int               FREQ_MAX    = 50,
  parameter logic [ACC_W-1:0] FTW_STEP    = ACC_W'(2**23),
  parameter int               PHASE_STEPS = 8,
  localparam int              FREQ_W      = $clog2(FREQ_MAX + 1),
  localparam int              PH_W        = (PHASE_STEPS > 1) ? $clog2(PHASE_STEPS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      w_ctrl,
  input  logic                      a_ctrl,
  input  logic                      p_ctrl,
  input  logic                      f_ctrl,
  output logic [ROM_AW-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_q,
  output logic [DATA_W+AMP_W-1:0]   wave_out,
  output logic                      wave_valid,
  output logic [1:0]                wave_sel,
  output logic [AMP_W-1:0]          amp,
  output logic [FREQ_W-1:0]         freq_mult,
  output logic [PH_W-1:0]           phase_idx
);

  localparam int                PROD_W       = DATA_W + AMP_W;
  localparam logic [ROM_AW-1:0] PH_ADDR_STEP = ROM_AW'((2**ROM_AW) / PHASE_STEPS);

  // Button bit order: 0 wave, 1 amplitude, 2 phase, 3 frequency
  logic [3:0]        sync1_q, sync1_d, sync2_q, sync2_d, edge_q, edge_d, pulse;
  logic [1:0]        wave_sel_q, wave_sel_d;
  logic [AMP_W-1:0]  amp_q, amp_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [ACC_W-1:0]  acc_q, acc_d, ftw;
  logic [ROM_AW-1:0] pa, rom_addr_q, rom_addr_d, addr1_q, addr1_d;
  logic [1:0]        sel0_q, sel0_d, sel1_q, sel1_d;
  logic [AMP_W-1:0]  amp0_q, amp0_d, amp1_q, amp1_d;
  logic              en0_q, en0_d, en1_q, en1_d;
  logic [ROM_AW-2:0] fold;
  logic [DATA_W-1:0] raw;
  logic [PROD_W-1:0] wave_q, wave_d;
  logic              valid_q, valid_d;

  always_comb begin
    sync1_d = {f_ctrl, p_ctrl, a_ctrl, w_ctrl};
    sync2_d = sync1_q;
    edge_d  = sync2_q;
    pulse   = sync2_q & ~edge_q;

    wave_sel_d = pulse[0] ? wave_sel_q + 2'd1 : wave_sel_q;

    amp_d = amp_q;
    if (pulse[1]) amp_d = (amp_q == AMP_W'(AMP_MAX)) ? AMP_W'(1) : amp_q + AMP_W'(1);

    phase_d = phase_q;
    if (pulse[2]) phase_d = (phase_q == PH_W'(PHASE_STEPS - 1)) ? '0 : phase_q + PH_W'(1);

    freq_d = freq_q;
    if (pulse[3]) freq_d = (freq_q == FREQ_W'(FREQ_MAX)) ? FREQ_W'(1) : freq_q + FREQ_W'(1);
  end

  // The ACC_W-wide product truncates, giving the tuning word modulo 2^ACC_W
  always_comb begin
    ftw        = ACC_W'(freq_q) * FTW_STEP;
    acc_d      = en ? acc_q + ftw : acc_q;
    pa         = acc_q[ACC_W-1 -: ROM_AW] + ROM_AW'(phase_q) * PH_ADDR_STEP;
    rom_addr_d = en ? pa : rom_addr_q;
    sel0_d     = en ? wave_sel_q : sel0_q;
    amp0_d     = en ? amp_q : amp0_q;
    en0_d      = en;
    addr1_d    = rom_addr_q;
    sel1_d     = sel0_q;
    amp1_d     = amp0_q;
    en1_d      = en0_q;

    fold = addr1_q[ROM_AW-1] ? ~addr1_q[ROM_AW-2:0] : addr1_q[ROM_AW-2:0];
    case (sel1_q)
      2'd0:    raw = rom_q;
      2'd1:    raw = addr1_q[ROM_AW-1 -: DATA_W];
      2'd2:    raw = addr1_q[ROM_AW-1] ? '0 : '1;
      default: raw = fold[ROM_AW-2 -: DATA_W];
    endcase

    // Only samples launched while enabled reach the output, so it freezes with en low
    wave_d  = en1_q ? PROD_W'(raw) * PROD_W'(amp1_q) : wave_q;
    valid_d = en1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      edge_q     <= '1;
      wave_sel_q <= '0;
      amp_q      <= AMP_W'(1);
      freq_q     <= FREQ_W'(1);
      phase_q    <= '0;
      acc_q      <= '0;
      rom_addr_q <= '0;
      addr1_q    <= '0;
      sel0_q     <= '0;
      sel1_q     <= '0;
      amp0_q     <= '0;
      amp1_q     <= '0;
      en0_q      <= 1'b0;
      en1_q      <= 1'b0;
      wave_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      edge_q     <= edge_d;
      wave_sel_q <= wave_sel_d;
      amp_q      <= amp_d;
      freq_q     <= freq_d;
      phase_q    <= phase_d;
      acc_q      <= acc_d;
      rom_addr_q <= rom_addr_d;
      addr1_q    <= addr1_d;
      sel0_q     <= sel0_d;
      sel1_q     <= sel1_d;
      amp0_q     <= amp0_d;
      amp1_q     <= amp1_d;
      en0_q      <= en0_d;
      en1_q      <= en1_d;
      wave_q     <= wave_d;
      valid_q    <= valid_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign wave_out   = wave_q;
  assign wave_valid = valid_q;
  assign wave_sel   = wave_sel_q;
  assign amp        = amp_q;
  assign freq_mult  = freq_q;
  assign phase_idx  = phase_q;

endmodule

// File: tb/tb_dds_wave_gen_ctrl.sv
// Directed bench for dds_wave_gen_ctrl with a behavioural 1-cycle-latency ROM model.
module tb_dds_wave_gen_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        w_ctrl = 1'b0, a_ctrl = 1'b0, p_ctrl = 1'b0, f_ctrl = 1'b0;
  logic [8:0]  rom_addr;
  logic [7:0]  rom_q = 8'd0;
  logic [11:0] wave_out;
  logic        wave_valid;
  logic [1:0]  wave_sel;
  logic [3:0]  amp;
  logic [5:0]  freq_mult;
  logic [2:0]  phase_idx;

  int checks = 0;
  int passes = 0;

  dds_wave_gen_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .w_ctrl(w_ctrl), .a_ctrl(a_ctrl), .p_ctrl(p_ctrl), .f_ctrl(f_ctrl),
    .rom_addr(rom_addr), .rom_q(rom_q),
    .wave_out(wave_out), .wave_valid(wave_valid),
    .wave_sel(wave_sel), .amp(amp), .freq_mult(freq_mult), .phase_idx(phase_idx)
  );

  always #10 clk = ~clk;

  // Stand-in sine ROM: any fixed address->data map works for checking the sine path
  function automatic logic [7:0] romModel(input logic [8:0] a);
    return a[8:1] ^ 8'hA5;
  endfunction

  always @(posedge clk) rom_q <= romModel(rom_addr);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One button press: {f,p,a,w} held 3 clk, released 3 clk; control updates on the 3rd edge
  task automatic applyStimulus(input logic [3:0] btns);
    {f_ctrl, p_ctrl, a_ctrl, w_ctrl} = btns;
    tick(3);
    {f_ctrl, p_ctrl, a_ctrl, w_ctrl} = 4'b0000;
    tick(3);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [8:0]  a0, aPrev, s;
    logic [11:0] w0;
    int          found;

    // Reset state
    en = 1'b1;
    tick(2);
    checkOutput("resetWaveSel", wave_sel, 0);
    checkOutput("resetAmp", amp, 1);
    checkOutput("resetFreq", freq_mult, 1);
    checkOutput("resetPhase", phase_idx, 0);
    checkOutput("resetWaveOut", wave_out, 0);
    checkOutput("resetValid", wave_valid, 0);
    checkOutput("resetRomAddr", rom_addr, 0);

    // First samples after release
    rst_n = 1'b1;
    tick(1);
    checkOutput("start1Addr", rom_addr, 0);
    checkOutput("start1Valid", wave_valid, 0);
    tick(1);
    checkOutput("start2Addr", rom_addr, 1);
    checkOutput("start2Valid", wave_valid, 0);
    tick(1);
    checkOutput("start3Addr", rom_addr, 2);
    checkOutput("start3Valid", wave_valid, 1);
    checkOutput("start3Out", wave_out, 165);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      s = rom_addr - 9'd2;
      checkOutput("sineOut", wave_out, 32'(romModel(s)));
    end

    // Sawtooth at freq 1
    applyStimulus(4'b0001);
    checkOutput("waveSelSaw", wave_sel, 1);
    tick(3);
    aPrev = rom_addr;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      checkOutput("sawStep", rom_addr, 32'(aPrev + 9'd1));
      s = rom_addr - 9'd2;
      checkOutput("sawOut", wave_out, 32'(s >> 1));
      aPrev = rom_addr;
    end
    found = 0;
    for (int i = 0; i < 600 && found == 0; i++) begin
      if (rom_addr == 9'd511) found = 1;
      else tick(1);
    end
    checkOutput("sawWrapReach", found, 1);
    tick(1);
    checkOutput("sawWrapZero", rom_addr, 0);

    // Phase offsets: 4 presses add half a cycle, 8 return to zero
    a0 = rom_addr;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0100);
      checkOutput("phaseIdx", phase_idx, 32'(i + 1));
    end
    checkOutput("phaseJump", rom_addr, 32'(a0 + 9'd280));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0100);
      checkOutput("phaseIdxWrap", phase_idx, 32'((i + 5) % 8));
    end
    checkOutput("phaseBack", rom_addr, 32'(a0 + 9'd48));

    // Square with amplitude up to 15, then wrap to 1
    applyStimulus(4'b0001);
    checkOutput("waveSelSquare", wave_sel, 2);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(4'b0010);
      checkOutput("ampStep", amp, 32'(i + 2));
    end
    tick(2);
    found = 0;
    for (int i = 0; i < 600 && found == 0; i++) begin
      s = rom_addr - 9'd2;
      if (!s[8]) found = 1;
      else tick(1);
    end
    checkOutput("squareHighReach", found, 1);
    checkOutput("squareHigh", wave_out, 3825);
    found = 0;
    for (int i = 0; i < 600 && found == 0; i++) begin
      s = rom_addr - 9'd2;
      if (s[8]) found = 1;
      else tick(1);
    end
    checkOutput("squareLowReach", found, 1);
    checkOutput("squareLow", wave_out, 0);
    applyStimulus(4'b0010);
    checkOutput("ampWrap", amp, 1);

    // Asynchronous reset mid-run clears state without a clock edge
    #3 rst_n = 1'b0;
    #1;
    checkOutput("midResetSel", wave_sel, 0);
    checkOutput("midResetValid", wave_valid, 0);
    checkOutput("midResetAddr", rom_addr, 0);
    tick(1);
    rst_n = 1'b1;
    tick(3);

    // Wave and frequency buttons in the same clock
    applyStimulus(4'b1001);
    checkOutput("dualSel", wave_sel, 1);
    checkOutput("dualFreq", freq_mult, 2);
    tick(3);
    aPrev = rom_addr;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checkOutput("stepTwo", rom_addr, 32'(aPrev + 9'd2));
      s = rom_addr - 9'd4;
      checkOutput("sawFreq2", wave_out, 32'(s >> 1));
      aPrev = rom_addr;
    end

    // Triangle
    applyStimulus(4'b0001);
    applyStimulus(4'b0001);
    checkOutput("waveSelTri", wave_sel, 3);
    tick(3);
    for (int i = 0; i < 12; i++) begin
      tick(13);
      s = rom_addr - 9'd4;
      checkOutput("triOut", wave_out, (s < 9'd256) ? 32'(s) : 32'(9'd511 - s));
    end

    // Frequency button held across reset release gives no increment
    f_ctrl = 1'b1;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    checkOutput("heldFreq", freq_mult, 1);
    f_ctrl = 1'b0;
    tick(4);
    checkOutput("heldFreqRelease", freq_mult, 1);
    applyStimulus(4'b1000);
    checkOutput("freqAfterHeld", freq_mult, 2);

    // Enable low for 10 clocks freezes address and output
    tick(5);
    a0 = rom_addr;
    en = 1'b0;
    tick(1);
    checkOutput("enOffValid1", wave_valid, 1);
    tick(1);
    checkOutput("enOffValid2", wave_valid, 1);
    w0 = wave_out;
    tick(1);
    checkOutput("enOffValid3", wave_valid, 0);
    tick(7);
    checkOutput("frozenAddr", rom_addr, 32'(a0));
    checkOutput("frozenOut", wave_out, 32'(w0));
    checkOutput("frozenValid", wave_valid, 0);
    en = 1'b1;
    tick(3);
    checkOutput("reEnableValid", wave_valid, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
